// File: rtl/datapath_p2_pkg.sv
// Shared definitions for the datapath_p2 slice.
// Holds the 5-bit IR opcode constants, the CON condition codes and a
// sign-extension helper used by the ALU.
package datapath_p2_pkg;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_SHR  = 5'b00111;
    localparam logic [4:0] OP_SHL  = 5'b01000;
    localparam logic [4:0] OP_ROR  = 5'b01001;
    localparam logic [4:0] OP_ROL  = 5'b01010;
    localparam logic [4:0] OP_ADDI = 5'b01011;
    localparam logic [4:0] OP_ANDI = 5'b01100;
    localparam logic [4:0] OP_ORI  = 5'b01101;
    localparam logic [4:0] OP_MUL  = 5'b01110;
    localparam logic [4:0] OP_DIV  = 5'b01111;
    localparam logic [4:0] OP_NEG  = 5'b10000;
    localparam logic [4:0] OP_NOT  = 5'b10001;
    localparam logic [4:0] OP_BR   = 5'b10010;
    localparam logic [4:0] OP_JAL  = 5'b10100;

    // CON compare selected by IR[20:19]
    localparam logic [1:0] CON_EQZ = 2'b00;
    localparam logic [1:0] CON_NEZ = 2'b01;
    localparam logic [1:0] CON_GEZ = 2'b10;
    localparam logic [1:0] CON_LTZ = 2'b11;

    function automatic logic [63:0] sext64(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

endpackage

// File: rtl/datapath_p2_alu.sv
// Combinational ALU: result = f(op, a, b), a comes from Y and b from the bus.
// Ports: op (IR[31:27]), inc_pc (forces b+1), a, b (32-bit), res (64-bit).
// 32-bit results are sign-extended; mul gives a full product, div packs {rem, quo}.
module datapath_alu
    import datapath_p2_pkg::*;
(
    input  logic [4:0]  op,
    input  logic        inc_pc,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [63:0] res
);

    logic signed [63:0] a_wide;
    logic signed [63:0] b_wide;
    logic signed [63:0] prod;
    logic signed [31:0] a_s;
    logic signed [31:0] div_b;
    logic signed [31:0] quo;
    logic signed [31:0] rem;
    logic [4:0]         sh;
    logic [63:0]        ror_dbl;
    logic [63:0]        rol_dbl;

    always_comb begin
        a_wide  = {{32{a[31]}}, a};
        b_wide  = {{32{b[31]}}, b};
        // Low 64 bits of the product of sign-extended operands is the signed product.
        prod    = a_wide * b_wide;
        a_s     = a;
        // Divisor forced non-zero so the divider never sees 0; the b == 0 case
        // is overridden below.
        div_b   = (b == 32'd0) ? 32'sd1 : b;
        quo     = a_s / div_b;
        rem     = a_s % div_b;
        sh      = b[4:0];
        ror_dbl = {a, a} >> sh;
        rol_dbl = {a, a} << sh;

        unique case (op)
            OP_LD, OP_LDI, OP_ST, OP_ADD,
            OP_ADDI, OP_BR, OP_JAL: res = sext64(a + b);
            OP_SUB:  res = sext64(a - b);
            OP_AND:  res = sext64(a & b);
            OP_OR:   res = sext64(a | b);
            OP_SHR:  res = sext64(a >> sh);
            OP_SHL:  res = sext64(a << sh);
            OP_ROR:  res = sext64(ror_dbl[31:0]);
            OP_ROL:  res = sext64(rol_dbl[63:32]);
            OP_ANDI: res = sext64(a & b);
            OP_ORI:  res = sext64(a | b);
            OP_MUL:  res = prod;
            OP_DIV:  res = (b == 32'd0) ? 64'd0 : {rem, quo};
            OP_NEG:  res = sext64(32'd0 - b);
            OP_NOT:  res = sext64(~b);
            default: res = sext64(a + b);
        endcase

        if (inc_pc) begin
            res = {32'd0, b + 32'd1};
        end
    end

endmodule

// File: rtl/datapath_p2.sv
// Single-bus CPU datapath: register file, special registers, Z/CON and the bus mux.
// Ports: outp (OutPort), *out bus-source enables, *in load enables, IR field selects
// (Gra/Grb/Grc, Rin/Rout/BAout, Cout), CONIn, Strobe, Clock, Clear (sync high), Mdatain.
module datapath_p2
    import datapath_p2_pkg::*;
(
    output logic [31:0] outp,
    input  logic        PCout,
    input  logic        Zhiout,
    input  logic        Zlowout,
    input  logic        MDRout,
    input  logic        HIout,
    input  logic        LOout,
    input  logic        InPortout,
    input  logic        MARin,
    input  logic        Zin,
    input  logic        PCin,
    input  logic        MDRin,
    input  logic        IRin,
    input  logic        Yin,
    input  logic        HIin,
    input  logic        LOin,
    input  logic        OutPortin,
    input  logic        IncPC,
    input  logic        Read,
    input  logic        Write,
    input  logic        Gra,
    input  logic        Grb,
    input  logic        Grc,
    input  logic        Rin,
    input  logic        Rout,
    input  logic        BAout,
    input  logic        Cout,
    input  logic        CONIn,
    input  logic        Strobe,
    input  logic        Clock,
    input  logic        Clear,
    input  logic [31:0] Mdatain
);

    logic [15:0][31:0] gpr;
    logic [31:0] pc, ir, mar, mdr, y, hi, lo, inport, outport;
    logic [63:0] z;
    logic        con;

    logic [31:0] bus;
    logic [31:0] r_bus;
    logic [31:0] c_sext;
    logic [31:0] mdr_in;
    logic [63:0] alu_res;
    logic [3:0]  reg_idx;
    logic [15:0] reg_dec;
    logic [15:0] rin_en;
    logic [15:0] rout_en;
    logic        con_next;

    // MAR and Write only matter to external memory.
    logic unused_ok;
    assign unused_ok = ^{mar, Write};

    // Several selects asserted together OR their fields.
    assign reg_idx = ({4{Gra}} & ir[26:23]) | ({4{Grb}} & ir[22:19]) | ({4{Grc}} & ir[18:15]);
    assign reg_dec = 16'd1 << reg_idx;
    assign rin_en  = {16{Rin}} & reg_dec;
    assign rout_en = {16{Rout | BAout}} & reg_dec;

    assign c_sext  = {{13{ir[18]}}, ir[18:0]};
    assign mdr_in  = Read ? Mdatain : bus;
    assign outp    = outport;

    // Register drive: BAout suppresses R0 so base addressing can read it as zero.
    always_comb begin
        r_bus = 32'd0;
        for (int i = 0; i < 16; i++) begin
            if (rout_en[i] && !(i == 0 && BAout)) begin
                r_bus = r_bus | gpr[i];
            end
        end
    end

    always_comb begin
        if (Rout || BAout)  bus = r_bus;
        else if (PCout)     bus = pc;
        else if (Zhiout)    bus = z[63:32];
        else if (Zlowout)   bus = z[31:0];
        else if (MDRout)    bus = mdr;
        else if (HIout)     bus = hi;
        else if (LOout)     bus = lo;
        else if (InPortout) bus = inport;
        else if (Cout)      bus = c_sext;
        else                bus = 32'd0;
    end

    always_comb begin
        unique case (ir[20:19])
            CON_EQZ: con_next = (bus == 32'd0);
            CON_NEZ: con_next = (bus != 32'd0);
            CON_GEZ: con_next = !bus[31];
            CON_LTZ: con_next = bus[31];
            default: con_next = 1'b0;
        endcase
    end

    datapath_alu u_alu (
        .op     (ir[31:27]),
        .inc_pc (IncPC),
        .a      (y),
        .b      (bus),
        .res    (alu_res)
    );

    always_ff @(posedge Clock) begin
        if (Clear) begin
            gpr     <= '0;
            pc      <= 32'd0;
            ir      <= 32'd0;
            mar     <= 32'd0;
            mdr     <= 32'd0;
            y       <= 32'd0;
            hi      <= 32'd0;
            lo      <= 32'd0;
            inport  <= 32'd0;
            outport <= 32'd0;
            z       <= 64'd0;
            con     <= 1'b0;
        end else begin
            for (int i = 0; i < 16; i++) begin
                if (rin_en[i]) gpr[i] <= bus;
            end
            if (PCin)      pc      <= bus;
            if (IRin)      ir      <= bus;
            if (MARin)     mar     <= bus;
            if (MDRin)     mdr     <= mdr_in;
            if (Yin)       y       <= bus;
            if (HIin)      hi      <= bus;
            if (LOin)      lo      <= bus;
            if (Strobe)    inport  <= Mdatain;
            if (OutPortin) outport <= bus;
            if (Zin)       z       <= alu_res;
            if (CONIn)     con     <= con_next;
        end
    end

endmodule

// File: tb/tb_datapath_p2.sv
module tb_datapath_p2;
    import datapath_p2_pkg::*;

    logic [31:0] outp;
    logic PCout, Zhiout, Zlowout, MDRout, HIout, LOout, InPortout;
    logic MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin, OutPortin;
    logic IncPC, Read, Write, Gra, Grb, Grc, Rin, Rout, BAout, Cout, CONIn, Strobe;
    logic Clock, Clear;
    logic [31:0] Mdatain;

    int checks = 0;
    int errors = 0;

    datapath_p2 dut (
        .outp(outp), .PCout(PCout), .Zhiout(Zhiout), .Zlowout(Zlowout), .MDRout(MDRout),
        .HIout(HIout), .LOout(LOout), .InPortout(InPortout), .MARin(MARin), .Zin(Zin),
        .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin), .HIin(HIin), .LOin(LOin),
        .OutPortin(OutPortin), .IncPC(IncPC), .Read(Read), .Write(Write), .Gra(Gra),
        .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout), .Cout(Cout),
        .CONIn(CONIn), .Strobe(Strobe), .Clock(Clock), .Clear(Clear), .Mdatain(Mdatain)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic idle_ctl();
        {PCout, Zhiout, Zlowout, MDRout, HIout, LOout, InPortout} = '0;
        {MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin, OutPortin} = '0;
        {IncPC, Read, Write, Gra, Grb, Grc, Rin, Rout, BAout, Cout, CONIn, Strobe} = '0;
        Clear = 1'b0;
    endtask

    // Apply current controls across one rising edge, then release them.
    task automatic tick();
        @(posedge Clock);
        #1;
        idle_ctl();
    endtask

    task automatic load_mdr(input logic [31:0] v);
        Read = 1'b1; MDRin = 1'b1; Mdatain = v;
        tick();
    endtask

    task automatic load_ir(input logic [31:0] v);
        load_mdr(v);
        MDRout = 1'b1; IRin = 1'b1;
        tick();
    endtask

    task automatic load_reg(input logic [3:0] idx, input logic [31:0] v);
        load_ir({5'd0, idx, 23'd0});
        load_mdr(v);
        MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1;
        tick();
    endtask

    initial begin
        idle_ctl();
        Mdatain = 32'd0;
        Clear = 1'b1;
        tick();
        chk("rst_pc",   {32'd0, dut.pc}, 64'd0);
        chk("rst_z",    dut.z, 64'd0);
        chk("rst_con",  {63'd0, dut.con}, 64'd0);
        chk("rst_outp", {32'd0, outp}, 64'd0);

        // Fetch
        PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1;
        tick();
        Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1; Mdatain = 32'h590F_FFFB;
        tick();
        MDRout = 1'b1; IRin = 1'b1;
        tick();
        chk("fetch_pc",  {32'd0, dut.pc}, 64'd1);
        chk("fetch_mar", {32'd0, dut.mar}, 64'd0);
        chk("fetch_ir",  {32'd0, dut.ir}, 64'h590F_FFFB);

        // Bus priority and idle bus
        PCout = 1'b1; MDRout = 1'b1;
        #1;
        chk("bus_prio", {32'd0, dut.bus}, 64'd1);
        idle_ctl();
        #1;
        chk("bus_idle", {32'd0, dut.bus}, 64'd0);

        // addi R2,R1,-5
        Grb = 1'b1; Rout = 1'b1; Yin = 1'b1;
        tick();
        Cout = 1'b1; Zin = 1'b1;
        tick();
        Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1;
        tick();
        chk("addi_y",  {32'd0, dut.y}, 64'd0);
        chk("addi_z",  dut.z, 64'hFFFF_FFFF_FFFF_FFFB);
        chk("addi_r2", {32'd0, dut.gpr[2]}, 64'h0000_0000_FFFF_FFFB);
        chk("addi_r1", {32'd0, dut.gpr[1]}, 64'd0);

        // mul / div with R3 = 7, R4 = 3
        load_reg(4'd3, 32'd7);
        load_reg(4'd4, 32'd3);
        load_ir({OP_MUL, 4'd0, 4'd3, 4'd4, 15'd0});
        Grb = 1'b1; Rout = 1'b1; Yin = 1'b1;
        tick();
        Grc = 1'b1; Rout = 1'b1; Zin = 1'b1;
        tick();
        chk("mul_z", dut.z, 64'd21);
        load_ir({OP_DIV, 4'd0, 4'd3, 4'd4, 15'd0});
        Grc = 1'b1; Rout = 1'b1; Zin = 1'b1;
        tick();
        chk("div_z", dut.z, {32'd1, 32'd2});
        load_reg(4'd4, 32'd0);
        load_ir({OP_DIV, 4'd0, 4'd3, 4'd4, 15'd0});
        Grc = 1'b1; Rout = 1'b1; Zin = 1'b1;
        tick();
        chk("div0_z", dut.z, 64'd0);

        // BAout on R0
        load_reg(4'd0, 32'h1234);
        load_ir(32'd0);
        Grb = 1'b1; BAout = 1'b1; Yin = 1'b1;
        #1;
        chk("ba_bus", {32'd0, dut.bus}, 64'd0);
        tick();
        chk("ba_y", {32'd0, dut.y}, 64'd0);
        Grb = 1'b1; Rout = 1'b1; Yin = 1'b1;
        tick();
        chk("rout_y", {32'd0, dut.y}, 64'h1234);

        // CON
        load_ir(32'h0018_0000);
        load_mdr(32'h8000_0000);
        MDRout = 1'b1; CONIn = 1'b1;
        tick();
        chk("con_ltz_neg", {63'd0, dut.con}, 64'd1);
        load_mdr(32'd0);
        MDRout = 1'b1; CONIn = 1'b1;
        tick();
        chk("con_ltz_zero", {63'd0, dut.con}, 64'd0);
        load_ir(32'd0);
        load_mdr(32'd0);
        MDRout = 1'b1; CONIn = 1'b1;
        tick();
        chk("con_eqz_zero", {63'd0, dut.con}, 64'd1);

        // ror 7 by 1, neg, IncPC wrap
        load_ir({OP_ROR, 4'd0, 4'd3, 19'd0});
        Grb = 1'b1; Rout = 1'b1; Yin = 1'b1;
        tick();
        load_mdr(32'd1);
        MDRout = 1'b1; Zin = 1'b1;
        tick();
        chk("ror_z", dut.z, 64'hFFFF_FFFF_8000_0003);
        load_ir({OP_NEG, 27'd0});
        load_mdr(32'd5);
        MDRout = 1'b1; Zin = 1'b1;
        tick();
        chk("neg_z", dut.z, 64'hFFFF_FFFF_FFFF_FFFB);
        load_mdr(32'hFFFF_FFFF);
        MDRout = 1'b1; Zin = 1'b1; IncPC = 1'b1;
        tick();
        chk("incpc_wrap_z", dut.z, 64'd0);

        // InPort -> OutPort, then Clear overriding active enables
        Strobe = 1'b1; Mdatain = 32'hA5;
        tick();
        InPortout = 1'b1; OutPortin = 1'b1;
        tick();
        chk("outp_a5", {32'd0, outp}, 64'hA5);
        InPortout = 1'b1; OutPortin = 1'b1; Yin = 1'b1; Clear = 1'b1;
        tick();
        chk("clr_outp", {32'd0, outp}, 64'd0);
        chk("clr_y",    {32'd0, dut.y}, 64'd0);
        chk("clr_r3",   {32'd0, dut.gpr[3]}, 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
